// File: rtl/ped_request_ctrl.sv
// Pedestrian crossing request stage: debounces the crosswalk button, requests a red
// phase from the light controller and sequences the WALK / flashing DONT_WALK lamps.
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYC   = 480_000,
  parameter int unsigned WALK_CYC       = 192_000_000,
  parameter int unsigned FLASH_CYC      = 96_000_000,
  parameter int unsigned BLINK_HALF_CYC = 12_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic ped_btn_n,
  input  logic ped_ack,
  input  logic veh_red,
  output logic ped_req,
  output logic ped_done,
  output logic walk_led,
  output logic dont_walk_led,
  output logic req_lamp,
  output logic fault
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RED,
    WALK,
    FLASH
  } state_e;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             db_prev_q, db_prev_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_q, press_d;

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             ped_req_q, ped_req_d;
  logic             done_q, done_d;
  logic             walk_q, walk_d;
  logic             dw_q, dw_d;
  logic             req_lamp_q, req_lamp_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] blink_q, blink_d;

  // Button levels are active-low: 1 = released. Press event fires one cycle after the
  // debounced level falls, so holding the button gives a single event.
  always_comb begin
    sync1_d   = ped_btn_n;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_cnt_d  = '0;
    db_prev_d = db_q;
    press_d   = db_prev_q & ~db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
    end
  end

  // Crossing sequencer; lamp outputs are computed for the cycle after the edge.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ped_req_d = 1'b0;
    done_d    = 1'b0;
    walk_d    = walk_q;
    dw_d      = dw_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    blink_d   = blink_q;

    if (press_q && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        blink_d = '0;
        walk_d  = 1'b0;
        dw_d    = 1'b1;
        if (press_q || pending_q) begin
          state_d   = REQ;
          ped_req_d = 1'b1;
          pending_d = 1'b0;
        end
      end
      REQ: begin
        ped_req_d = 1'b1;
        if (ped_ack) begin
          state_d   = WAIT_RED;
          ped_req_d = 1'b0;
        end
      end
      WAIT_RED: begin
        if (veh_red) begin
          state_d = WALK;
          cnt_d   = '0;
          blink_d = '0;
          walk_d  = 1'b1;
          dw_d    = 1'b0;
        end
      end
      WALK: begin
        if (!veh_red) begin
          state_d = IDLE;
          cnt_d   = '0;
          blink_d = '0;
          walk_d  = 1'b0;
          dw_d    = 1'b1;
          fault_d = 1'b1;
        end else if (cnt_q == CNT_W'(WALK_CYC - 1)) begin
          state_d = FLASH;
          cnt_d   = '0;
          blink_d = '0;
          walk_d  = 1'b0;
          dw_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FLASH: begin
        if (!veh_red) begin
          state_d = IDLE;
          cnt_d   = '0;
          blink_d = '0;
          walk_d  = 1'b0;
          dw_d    = 1'b1;
          fault_d = 1'b1;
        end else if (cnt_q == CNT_W'(FLASH_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          blink_d = '0;
          dw_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (blink_q == CNT_W'(BLINK_HALF_CYC - 1)) begin
            blink_d = '0;
            dw_d    = ~dw_q;
          end else begin
            blink_d = blink_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_lamp_d = (state_d == REQ) || (state_d == WAIT_RED) || pending_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      ped_req_q  <= 1'b0;
      done_q     <= 1'b0;
      walk_q     <= 1'b0;
      dw_q       <= 1'b1;
      req_lamp_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      blink_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ped_req_q  <= ped_req_d;
      done_q     <= done_d;
      walk_q     <= walk_d;
      dw_q       <= dw_d;
      req_lamp_q <= req_lamp_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
    end
  end

  assign ped_req       = ped_req_q;
  assign ped_done      = done_q;
  assign walk_led      = walk_q;
  assign dont_walk_led = dw_q;
  assign req_lamp      = req_lamp_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with a queue-based expected-output scoreboard.
module tb_ped_request_ctrl;

  logic sys_clk;
  logic sys_rst_n;
  logic ped_btn_n;
  logic ped_ack;
  logic veh_red;
  logic ped_req;
  logic ped_done;
  logic walk_led;
  logic dont_walk_led;
  logic req_lamp;
  logic fault;

  ped_request_ctrl #(
    .DEBOUNCE_CYC  (4),
    .WALK_CYC      (20),
    .FLASH_CYC     (8),
    .BLINK_HALF_CYC(2)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .ped_btn_n    (ped_btn_n),
    .ped_ack      (ped_ack),
    .veh_red      (veh_red),
    .ped_req      (ped_req),
    .ped_done     (ped_done),
    .walk_led     (walk_led),
    .dont_walk_led(dont_walk_led),
    .req_lamp     (req_lamp),
    .fault        (fault)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Output vector layout: {ped_req, ped_done, walk_led, dont_walk_led, req_lamp, fault}
  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [5:0] outs();
    return {ped_req, ped_done, walk_led, dont_walk_led, req_lamp, fault};
  endfunction

  task automatic expect_out(input string tag, input logic [5:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t       e;
    logic [5:0] obs;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e   = sb_q.pop_front();
    obs = outs();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  // Queue the expectation, advance one clock, compare on the falling edge.
  task automatic step(input string tag, input logic [5:0] exp);
    expect_out(tag, exp);
    @(negedge sys_clk);
    compare_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    pat = 8'b1100_1100;

    sys_rst_n = 1'b0;
    ped_btn_n = 1'b1;
    ped_ack   = 1'b0;
    veh_red   = 1'b0;
    repeat (2) @(negedge sys_clk);
    expect_out("reset", 6'b000100);
    compare_front();
    sys_rst_n = 1'b1;

    // Short glitches never reach the debounce threshold
    for (int g = 1; g <= 3; g++) begin
      ped_btn_n = 1'b0;
      repeat (g) @(negedge sys_clk);
      ped_btn_n = 1'b1;
      repeat (10) @(negedge sys_clk);
      expect_out($sformatf("glitch%0d", g), 6'b000100);
      compare_front();
    end

    // Crossing 1: clean press, ped_req after 8 edges, full normal sequence
    ped_btn_n = 1'b0;
    for (int i = 1; i <= 7; i++) step($sformatf("press_wait%0d", i), 6'b000100);
    step("press_req", 6'b100110);
    for (int i = 0; i < 3; i++) step("req_hold", 6'b100110);
    ped_ack = 1'b1;
    step("ack", 6'b000110);
    ped_ack = 1'b0;
    step("wait_red", 6'b000110);
    veh_red = 1'b1;
    step("walk0", 6'b001000);
    ped_btn_n = 1'b1;
    for (int i = 1; i < 20; i++) step($sformatf("walk%0d", i), 6'b001000);
    for (int i = 0; i < 8; i++) step($sformatf("flash%0d", i), {3'b000, pat[7-i], 2'b00});
    step("done", 6'b010100);
    step("after_done", 6'b000100);

    // Crossing 2: red lost at walk cycle 10 -> fault, no done pulse
    veh_red   = 1'b0;
    ped_btn_n = 1'b0;
    repeat (7) @(negedge sys_clk);
    step("f_req", 6'b100110);
    ped_btn_n = 1'b1;
    ped_ack   = 1'b1;
    step("f_ack", 6'b000110);
    ped_ack = 1'b0;
    for (int i = 0; i < 6; i++) step("f_wait_red", 6'b000110);
    veh_red = 1'b1;
    step("f_walk0", 6'b001000);
    for (int i = 1; i <= 10; i++) step($sformatf("f_walk%0d", i), 6'b001000);
    veh_red = 1'b0;
    step("f_drop", 6'b000101);
    for (int i = 0; i < 3; i++) step("f_idle", 6'b000101);

    // Crossing 3: fault stays set; press during WALK becomes pending and is re-issued
    ped_btn_n = 1'b0;
    repeat (7) @(negedge sys_clk);
    step("c3_req", 6'b100111);
    ped_btn_n = 1'b1;
    ped_ack   = 1'b1;
    step("c3_ack", 6'b000111);
    ped_ack = 1'b0;
    for (int i = 0; i < 8; i++) step("c3_wait_red", 6'b000111);
    veh_red = 1'b1;
    step("c3_walk0", 6'b001001);
    ped_btn_n = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step($sformatf("c3_walk%0d", i), {4'b0010, (i >= 8) ? 1'b1 : 1'b0, 1'b1});
      if (i == 12) ped_btn_n = 1'b1;
    end
    for (int i = 0; i < 8; i++) step($sformatf("c3_flash%0d", i), {3'b000, pat[7-i], 2'b11});
    step("c3_done", 6'b010111);
    step("c3_rereq", 6'b100111);

    // Crossing 4: pending set again, then reset asserted mid-FLASH
    ped_ack = 1'b1;
    step("c4_ack", 6'b000111);
    ped_ack = 1'b0;
    step("c4_walk0", 6'b001001);
    ped_btn_n = 1'b0;
    for (int i = 1; i < 20; i++) begin
      step($sformatf("c4_walk%0d", i), {4'b0010, (i >= 8) ? 1'b1 : 1'b0, 1'b1});
      if (i == 12) ped_btn_n = 1'b1;
    end
    for (int i = 0; i < 3; i++) step($sformatf("c4_flash%0d", i), {3'b000, pat[7-i], 2'b11});
    sys_rst_n = 1'b0;
    #1;
    expect_out("rst_async", 6'b000100);
    compare_front();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    veh_red   = 1'b0;
    repeat (20) @(negedge sys_clk);
    expect_out("post_rst_idle", 6'b000100);
    compare_front();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
